// File: rtl/axi_rd_arbiter_n.sv
// Round-robin AXI read-address arbiter and read-data router for NUM_PORTS readers sharing one AR/R channel.
// The granted port index rides in the ARID MSBs and steers R beats back; per-port burst counts cap outstanding reads.
module axi_rd_arbiter_n #(
    parameter int  NUM_PORTS       = 4,
    parameter int  ID_WIDTH        = 8,
    parameter int  ADDR_WIDTH      = 33,
    parameter int  DATA_WIDTH      = 256,
    parameter int  MAX_OUTSTANDING = 4,
    localparam int PORT_BITS       = ($clog2(NUM_PORTS) < 1) ? 1 : $clog2(NUM_PORTS),
    localparam int RID_W           = ID_WIDTH - PORT_BITS,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            active_ports_in,
    input  logic [NUM_PORTS*RID_W-1:0]      rd_id_in,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr_in,
    input  logic [NUM_PORTS*8-1:0]          rd_len_in,
    input  logic [NUM_PORTS-1:0]            rd_info_valid_in,
    output logic [NUM_PORTS-1:0]            rd_info_rdy_out,
    output logic [DATA_WIDTH-1:0]           rd_data_out,
    output logic                            rd_data_last_out,
    output logic [NUM_PORTS-1:0]            rd_data_valid_out,
    input  logic [NUM_PORTS-1:0]            rd_data_rdy_in,
    output logic [ID_WIDTH-1:0]             axi_arid_out,
    output logic [ADDR_WIDTH-1:0]           axi_araddr_out,
    output logic [7:0]                      axi_arlen_out,
    output logic                            axi_arvalid_out,
    input  logic                            axi_arready_in,
    input  logic [ID_WIDTH-1:0]             axi_rid_in,
    input  logic [DATA_WIDTH-1:0]           axi_rdata_in,
    input  logic                            axi_rlast_in,
    input  logic                            axi_rvalid_in,
    output logic                            axi_rready_out,
    output logic                            outstanding_any_out,
    output logic                            err_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int                PID_W      = PORT_BITS + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PID_W-1:0]  PORT_LIMIT = PID_W'(NUM_PORTS);

    state_t                  state_q, state_d;
    logic [PORT_BITS-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]        cnt_d [NUM_PORTS];
    logic [ID_WIDTH-1:0]     arid_q, arid_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    err_q, err_d;
    logic                    any_q, any_d;

    logic [NUM_PORTS-1:0]    eligible;
    logic                    grant_found;
    logic [PORT_BITS-1:0]    grant_idx;
    logic [RID_W-1:0]        sel_id;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [7:0]              sel_len;
    logic [PORT_BITS-1:0]    issue_port;
    logic                    ar_hs;
    logic [PORT_BITS-1:0]    r_pid;
    logic                    r_pid_ok;
    logic                    r_done;
    logic [NUM_PORTS-1:0]    inc_vec;
    logic [NUM_PORTS-1:0]    dec_vec;
    logic                    unused_rid;

    // Modular increment that stays correct when NUM_PORTS is not a power of two.
    function automatic logic [PORT_BITS-1:0] wrap_inc(input logic [PORT_BITS-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_PORTS) sum -= NUM_PORTS;
        return PORT_BITS'(sum);
    endfunction

    assign issue_port = arid_q[ID_WIDTH-1 -: PORT_BITS];
    assign ar_hs      = (state_q == ISSUE) & axi_arready_in;
    assign r_pid      = axi_rid_in[ID_WIDTH-1 -: PORT_BITS];
    assign r_pid_ok   = {1'b0, r_pid} < PORT_LIMIT;
    assign r_done     = axi_rvalid_in & axi_rready_out & axi_rlast_in & r_pid_ok;
    assign unused_rid = ^axi_rid_in[RID_W-1:0];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = rd_info_valid_in[p] & active_ports_in[p] & (cnt_q[p] < CNT_MAX);
        end
    end

    // Search ptr, ptr+1, ... and take the first eligible port.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_found && eligible[wrap_inc(ptr_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_inc(ptr_q, i);
            end
        end
    end

    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == PORT_BITS'(p)) begin
                sel_id   = rd_id_in[p*RID_W +: RID_W];
                sel_addr = rd_addr_in[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = rd_len_in[p*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            arid_q   <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            err_q    <= 1'b0;
            any_q    <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            arid_q   <= arid_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            err_q    <= err_d;
            any_q    <= any_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        arid_d   = arid_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d  = ISSUE;
                    arid_d   = {grant_idx, sel_id};
                    araddr_d = sel_addr;
                    arlen_d  = sel_len;
                end
            end
            ISSUE: begin
                if (axi_arready_in) begin
                    state_d = IDLE;
                    ptr_d   = wrap_inc(issue_port, 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            inc_vec[p] = ar_hs & (issue_port == PORT_BITS'(p));
            dec_vec[p] = r_done & (r_pid == PORT_BITS'(p));
        end
    end

    // A final beat for a port with nothing outstanding is flagged and the count holds at zero.
    always_comb begin
        err_d = err_q | (axi_rvalid_in & ~r_pid_ok);
        any_d = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            any_d    = any_d | (cnt_q[p] != '0);
            if (inc_vec[p] && !dec_vec[p]) begin
                cnt_d[p] = cnt_q[p] + 1'b1;
            end else if (dec_vec[p] && !inc_vec[p]) begin
                if (cnt_q[p] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[p] = cnt_q[p] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_info_rdy_out   = '0;
        rd_data_valid_out = '0;
        axi_rready_out    = 1'b1;
        axi_arvalid_out   = (state_q == ISSUE);
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (state_q == IDLE && grant_found && grant_idx == PORT_BITS'(p)) begin
                rd_info_rdy_out[p] = 1'b1;
            end
            if (r_pid_ok && r_pid == PORT_BITS'(p)) begin
                rd_data_valid_out[p] = axi_rvalid_in;
                axi_rready_out       = rd_data_rdy_in[p];
            end
        end
    end

    assign axi_arid_out        = arid_q;
    assign axi_araddr_out      = araddr_q;
    assign axi_arlen_out       = arlen_q;
    assign rd_data_out         = axi_rdata_in;
    assign rd_data_last_out    = axi_rlast_in;
    assign outstanding_any_out = any_q;
    assign err_out             = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter_n.sv
// Self-checking bench for axi_rd_arbiter_n (3 ports, limit 2): directed scenarios plus a random phase,
// all compared every cycle against a cycle-level behavioural model of the arbitration rules.
module tb_axi_rd_arbiter_n;

    localparam int NP   = 3;
    localparam int PB   = 2;
    localparam int IDW  = 8;
    localparam int RW   = IDW - PB;
    localparam int AW   = 33;
    localparam int DW   = 64;
    localparam int MAXO = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     active_ports_in;
    logic [NP*RW-1:0]  rd_id_in;
    logic [NP*AW-1:0]  rd_addr_in;
    logic [NP*8-1:0]   rd_len_in;
    logic [NP-1:0]     rd_info_valid_in;
    logic [NP-1:0]     rd_info_rdy_out;
    logic [DW-1:0]     rd_data_out;
    logic              rd_data_last_out;
    logic [NP-1:0]     rd_data_valid_out;
    logic [NP-1:0]     rd_data_rdy_in;
    logic [IDW-1:0]    axi_arid_out;
    logic [AW-1:0]     axi_araddr_out;
    logic [7:0]        axi_arlen_out;
    logic              axi_arvalid_out;
    logic              axi_arready_in;
    logic [IDW-1:0]    axi_rid_in;
    logic [DW-1:0]     axi_rdata_in;
    logic              axi_rlast_in;
    logic              axi_rvalid_in;
    logic              axi_rready_out;
    logic              outstanding_any_out;
    logic              err_out;

    // Per-port request registers held by the bench until the model says they were accepted.
    logic [RW-1:0]     req_id   [NP];
    logic [AW-1:0]     req_addr [NP];
    logic [7:0]        req_len  [NP];
    logic [NP-1:0]     req_v;

    // Behavioural reference model state.
    bit                m_busy;
    int                m_port;
    int                m_ptr;
    int                m_cnt [NP];
    bit                m_err;
    bit                m_any;
    logic [IDW-1:0]    m_arid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;

    int checks;
    int errors;

    for (genvar g = 0; g < NP; g++) begin : g_pack
        assign rd_id_in[g*RW +: RW]   = req_id[g];
        assign rd_addr_in[g*AW +: AW] = req_addr[g];
        assign rd_len_in[g*8 +: 8]    = req_len[g];
    end
    assign rd_info_valid_in = req_v;

    always #5 clk = ~clk;

    axi_rd_arbiter_n #(
        .NUM_PORTS       (NP),
        .ID_WIDTH        (IDW),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .active_ports_in     (active_ports_in),
        .rd_id_in            (rd_id_in),
        .rd_addr_in          (rd_addr_in),
        .rd_len_in           (rd_len_in),
        .rd_info_valid_in    (rd_info_valid_in),
        .rd_info_rdy_out     (rd_info_rdy_out),
        .rd_data_out         (rd_data_out),
        .rd_data_last_out    (rd_data_last_out),
        .rd_data_valid_out   (rd_data_valid_out),
        .rd_data_rdy_in      (rd_data_rdy_in),
        .axi_arid_out        (axi_arid_out),
        .axi_araddr_out      (axi_araddr_out),
        .axi_arlen_out       (axi_arlen_out),
        .axi_arvalid_out     (axi_arvalid_out),
        .axi_arready_in      (axi_arready_in),
        .axi_rid_in          (axi_rid_in),
        .axi_rdata_in        (axi_rdata_in),
        .axi_rlast_in        (axi_rlast_in),
        .axi_rvalid_in       (axi_rvalid_in),
        .axi_rready_out      (axi_rready_out),
        .outstanding_any_out (outstanding_any_out),
        .err_out             (err_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_port   = 0;
        m_ptr    = 0;
        m_err    = 1'b0;
        m_any    = 1'b0;
        m_arid   = '0;
        m_araddr = '0;
        m_arlen  = '0;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    endtask

    task automatic set_req(input int p);
        logic [63:0] r;
        r           = {$urandom, $urandom};
        req_id[p]   = RW'($urandom);
        req_addr[p] = r[AW-1:0];
        req_len[p]  = 8'($urandom);
        req_v[p]    = 1'b1;
    endtask

    // One clock: called just after a negedge with inputs set; checks outputs, advances the model.
    task automatic step();
        int            g;
        int            pid;
        int            inc_p;
        int            dec_p;
        bit            pid_ok;
        bit            n_any;
        logic [NP-1:0] exp_rdy;
        logic [NP-1:0] exp_dv;
        logic          exp_rr;
        #1;
        g       = -1;
        pid     = int'(axi_rid_in[IDW-1 -: PB]);
        pid_ok  = (pid < NP);
        exp_rdy = '0;
        exp_dv  = '0;
        exp_rr  = 1'b1;
        if (pid_ok) begin
            exp_rr      = rd_data_rdy_in[pid];
            exp_dv[pid] = axi_rvalid_in;
        end
        if (!m_busy) begin
            for (int i = 0; i < NP; i++) begin
                int p = (m_ptr + i) % NP;
                if (g < 0 && req_v[p] && active_ports_in[p] && m_cnt[p] < MAXO) g = p;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;

        if (!rst) begin
            check("info_rdy",   64'(rd_info_rdy_out),     64'(exp_rdy));
            check("arvalid",    64'(axi_arvalid_out),     64'(m_busy));
            check("arid",       64'(axi_arid_out),        64'(m_arid));
            check("araddr",     64'(axi_araddr_out),      64'(m_araddr));
            check("arlen",      64'(axi_arlen_out),       64'(m_arlen));
            check("data_valid", 64'(rd_data_valid_out),   64'(exp_dv));
            check("rready",     64'(axi_rready_out),      64'(exp_rr));
            check("rdata",      64'(rd_data_out),         64'(axi_rdata_in));
            check("rlast",      64'(rd_data_last_out),    64'(axi_rlast_in));
            check("err",        64'(err_out),             64'(m_err));
            check("out_any",    64'(outstanding_any_out), 64'(m_any));
        end

        if (rst) begin
            model_reset();
        end else begin
            n_any = 1'b0;
            for (int p = 0; p < NP; p++) if (m_cnt[p] != 0) n_any = 1'b1;
            inc_p = (m_busy && axi_arready_in) ? m_port : -1;
            dec_p = (axi_rvalid_in && exp_rr && axi_rlast_in && pid_ok) ? pid : -1;
            if (axi_rvalid_in && !pid_ok) m_err = 1'b1;
            if (inc_p >= 0 && inc_p != dec_p) m_cnt[inc_p]++;
            if (dec_p >= 0 && dec_p != inc_p) begin
                if (m_cnt[dec_p] == 0) m_err = 1'b1;
                else m_cnt[dec_p]--;
            end
            if (inc_p >= 0) begin
                m_busy = 1'b0;
                m_ptr  = (m_port + 1) % NP;
            end else if (g >= 0) begin
                m_busy   = 1'b1;
                m_port   = g;
                m_arid   = {PB'(g), req_id[g]};
                m_araddr = req_addr[g];
                m_arlen  = req_len[g];
            end
            m_any = n_any;
        end

        @(posedge clk);
        @(negedge clk);
        if (!rst && g >= 0) req_v[g] = 1'b0;
    endtask

    task automatic do_reset();
        req_v          = '0;
        axi_rvalid_in  = 1'b0;
        axi_rlast_in   = 1'b0;
        axi_arready_in = 1'b0;
        rst            = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send_last(input int p, input logic [NP-1:0] rdy);
        axi_rid_in     = {PB'(p), RW'($urandom)};
        axi_rdata_in   = {$urandom, $urandom};
        axi_rlast_in   = 1'b1;
        axi_rvalid_in  = 1'b1;
        rd_data_rdy_in = rdy;
    endtask

    task automatic r_idle();
        axi_rvalid_in = 1'b0;
        axi_rlast_in  = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        active_ports_in = '0;
        req_v           = '0;
        rd_data_rdy_in  = '0;
        axi_arready_in  = 1'b0;
        axi_rid_in      = '0;
        axi_rdata_in    = '0;
        axi_rlast_in    = 1'b0;
        axi_rvalid_in   = 1'b0;
        for (int p = 0; p < NP; p++) begin
            req_id[p]   = '0;
            req_addr[p] = '0;
            req_len[p]  = '0;
        end
        model_reset();
        @(negedge clk);

        // Reset state.
        do_reset();
        step();
        check("reset_arvalid", 64'(axi_arvalid_out), 64'd0);
        check("reset_arid",    64'(axi_arid_out),    64'd0);

        // All active, all valid, arready high: round robin 0,1,2,0,... until every port hits the limit.
        active_ports_in = '1;
        axi_arready_in  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            for (int p = 0; p < NP; p++) if (!req_v[p]) set_req(p);
            step();
        end
        check("limit_all_stall", 64'(axi_arvalid_out), 64'd0);

        // Only ports 0 and 2 active: port 1 is skipped and never acknowledged.
        do_reset();
        active_ports_in = 3'b101;
        axi_arready_in  = 1'b1;
        for (int c = 0; c < 12; c++) begin
            for (int p = 0; p < NP; p++) if (!req_v[p]) set_req(p);
            step();
        end
        req_v = '0;

        // Port 1 alone: two bursts fill its limit, a final beat frees a slot for a third.
        do_reset();
        active_ports_in = '1;
        axi_arready_in  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (!req_v[1]) set_req(1);
            step();
        end
        check("limit_port1_stall", 64'(axi_arvalid_out), 64'd0);
        send_last(1, 3'b010);
        step();
        r_idle();
        for (int c = 0; c < 4; c++) step();

        // arready held low in ISSUE: AR fields frozen while other ports toggle their valids.
        do_reset();
        req_v = '0;
        set_req(0);
        step();
        for (int c = 0; c < 5; c++) begin
            req_v[1] = ~req_v[1];
            req_v[2] = (c % 2 == 0);
            if (req_v[1]) set_req(1);
            step();
        end
        check("stall_arvalid", 64'(axi_arvalid_out), 64'd1);
        axi_arready_in = 1'b1;
        req_v          = '0;
        step();
        step();

        // Out-of-range port ID: beat dropped, rready forced high, sticky error until reset.
        do_reset();
        axi_rid_in     = {2'b11, 6'h15};
        axi_rdata_in   = 64'hdead_beef_0123_4567;
        axi_rvalid_in  = 1'b1;
        axi_rlast_in   = 1'b0;
        rd_data_rdy_in = '0;
        step();
        r_idle();
        for (int c = 0; c < 4; c++) step();
        check("err_sticky", 64'(err_out), 64'd1);
        do_reset();
        step();
        check("err_cleared", 64'(err_out), 64'd0);

        // Final beat for port 2 in the same cycle as its next AR handshake: count stays 1.
        do_reset();
        active_ports_in = '1;
        axi_arready_in  = 1'b1;
        set_req(2);
        step();
        step();
        set_req(2);
        step();
        send_last(2, 3'b100);
        step();
        r_idle();
        for (int c = 0; c < 3; c++) step();
        check("same_cycle_any", 64'(outstanding_any_out), 64'd1);

        // Reset asserted mid-ISSUE drops arvalid on the following cycle.
        do_reset();
        axi_arready_in = 1'b0;
        set_req(0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_v = '0;
        step();
        check("reset_mid_issue", 64'(axi_arvalid_out), 64'd0);

        // Random traffic; R final beats only target ports that have bursts outstanding.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            int cand [$];
            active_ports_in = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '1;
            for (int p = 0; p < NP; p++) if (!req_v[p] && $urandom_range(0, 1) == 1) set_req(p);
            axi_arready_in = 1'($urandom_range(0, 1));
            rd_data_rdy_in = NP'($urandom);
            axi_rdata_in   = {$urandom, $urandom};
            cand = {};
            for (int p = 0; p < NP; p++) if (m_cnt[p] > 0) cand.push_back(p);
            if (cand.size() > 0 && $urandom_range(0, 9) < 6) begin
                axi_rid_in    = {PB'(cand[$urandom_range(0, cand.size() - 1)]), RW'($urandom)};
                axi_rvalid_in = 1'b1;
                axi_rlast_in  = 1'($urandom_range(0, 1));
            end else begin
                axi_rid_in    = IDW'($urandom);
                axi_rvalid_in = 1'b0;
                axi_rlast_in  = 1'($urandom_range(0, 1));
            end
            step();
        end
        check("random_no_err", 64'(err_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
